// File: rtl/sti_rx_unpack.sv
`default_nettype none
// ============================================================================
// Module      : sti_rx_unpack
// Description : Serial frame receiver plus byte unpacker. Rebuilds each
//               MSB-first serial frame into a right-aligned word, reports its
//               bit length, splits good words into sequential 8-bit pixel
//               writes, flags malformed frames and raises a sticky finish
//               flag once the upstream stream has ended and writes drained.
// Revision    : 1.0 - initial release
// ============================================================================
module sti_rx_unpack #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset,          // synchronous, active-low
   input  logic              si_data,
   input  logic              si_valid,
   input  logic              stream_end,
   output logic [31:0]       rx_word,
   output logic [5:0]        rx_len,
   output logic              rx_word_valid,
   output logic              rx_err,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_data,
   output logic              rx_finish
);

   // Receiver states
   typedef enum logic [1:0] {
      R_IDLE  = 2'd0,
      R_SHIFT = 2'd1,
      R_DROP  = 2'd2
   } rx_state_t;

   // Packer states
   typedef enum logic [0:0] {
      P_IDLE  = 1'b0,
      P_WRITE = 1'b1
   } pk_state_t;

   localparam logic [5:0] C_MAX_BITS = 6'd32;

   rx_state_t         r_rx_state;
   logic [31:0]       r_shreg;
   logic [5:0]        r_cnt;

   pk_state_t         r_pk_state;
   logic [31:0]       r_pword;
   logic [1:0]        r_prem;
   logic [ADDR_W-1:0] r_ptr;

   logic              r_pend;

   logic              w_len_ok;
   logic [1:0]        w_load_idx;
   logic [1:0]        w_next_idx;
   logic              w_end_seen;
   logic              w_all_idle;

   // A frame is good only if it ends on a whole byte (8/16/24/32 bits);
   // the counter is never zero while shifting, but guard it anyway.
   assign w_len_ok   = (r_cnt[2:0] == 3'b000) && (r_cnt != 6'd0);

   // Index of the most significant byte of the word being loaded:
   // len 8 -> 0, 16 -> 1, 24 -> 2, 32 -> 3 (bits [4:3] minus one, mod 4).
   assign w_load_idx = rx_len[4:3] - 2'd1;

   // Index of the next byte to emit while draining.
   assign w_next_idx = r_prem - 2'd1;

   // The end request is honoured on the very cycle it arrives.
   assign w_end_seen = r_pend | stream_end;

   // Nothing in flight: receiver idle, packer idle, no load pending.
   assign w_all_idle = (r_rx_state == R_IDLE) && (r_pk_state == P_IDLE) &&
                       !rx_word_valid && !mem_wr;

   // Receiver FSM: shifts in serial bits and classifies each frame on its end.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_rx_state    <= R_IDLE;
         r_shreg       <= 32'd0;
         r_cnt         <= 6'd0;
         rx_word       <= 32'd0;
         rx_len        <= 6'd0;
         rx_word_valid <= 1'b0;
         rx_err        <= 1'b0;
      end else begin
         rx_word_valid <= 1'b0;
         rx_err        <= 1'b0;
         if (rx_finish) begin
            // Stream is over: ignore any further serial activity.
            r_rx_state <= R_IDLE;
            r_cnt      <= 6'd0;
         end else begin
            case (r_rx_state)
               R_IDLE: begin
                  if (si_valid) begin
                     r_shreg    <= {31'd0, si_data};
                     r_cnt      <= 6'd1;
                     r_rx_state <= R_SHIFT;
                  end
               end
               R_SHIFT: begin
                  if (si_valid) begin
                     if (r_cnt == C_MAX_BITS) begin
                        // 33rd bit: overflow, discard the rest of the burst.
                        rx_err     <= 1'b1;
                        r_rx_state <= R_DROP;
                     end else begin
                        r_shreg <= {r_shreg[30:0], si_data};
                        r_cnt   <= r_cnt + 6'd1;
                     end
                  end else begin
                     if (w_len_ok) begin
                        rx_word       <= r_shreg;
                        rx_len        <= r_cnt;
                        rx_word_valid <= 1'b1;
                     end else begin
                        rx_err <= 1'b1;
                     end
                     r_cnt      <= 6'd0;
                     r_rx_state <= R_IDLE;
                  end
               end
               R_DROP: begin
                  if (!si_valid) begin
                     r_cnt      <= 6'd0;
                     r_rx_state <= R_IDLE;
                  end
               end
               default: begin
                  r_cnt      <= 6'd0;
                  r_rx_state <= R_IDLE;
               end
            endcase
         end
      end
   end

   // Packer FSM: emits one byte per cycle, most significant byte first, on
   // consecutive wrapping addresses. The registered rx_word_valid pulse is
   // the load strobe, so the first write lands one cycle after it.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_pk_state <= P_IDLE;
         r_pword    <= 32'd0;
         r_prem     <= 2'd0;
         r_ptr      <= '0;
         mem_wr     <= 1'b0;
         mem_addr   <= '0;
         mem_data   <= 8'd0;
      end else begin
         case (r_pk_state)
            P_IDLE: begin
               mem_wr <= 1'b0;
               if (rx_word_valid) begin
                  r_pword    <= rx_word;
                  mem_wr     <= 1'b1;
                  mem_addr   <= r_ptr;
                  mem_data   <= rx_word[{w_load_idx, 3'b000} +: 8];
                  r_ptr      <= r_ptr + ADDR_W'(1);
                  r_prem     <= w_load_idx;
                  r_pk_state <= P_WRITE;
               end
            end
            P_WRITE: begin
               if (r_prem != 2'd0) begin
                  mem_wr   <= 1'b1;
                  mem_addr <= r_ptr;
                  mem_data <= r_pword[{w_next_idx, 3'b000} +: 8];
                  r_ptr    <= r_ptr + ADDR_W'(1);
                  r_prem   <= w_next_idx;
               end else begin
                  // Last byte already presented; mem_data holds its value.
                  mem_wr     <= 1'b0;
                  r_pk_state <= P_IDLE;
               end
            end
            default: begin
               mem_wr     <= 1'b0;
               r_pk_state <= P_IDLE;
            end
         endcase
      end
   end

   // Finish tracking: remember the end request, then raise the sticky flag
   // once the last frame and all its writes have fully drained.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_pend    <= 1'b0;
         rx_finish <= 1'b0;
      end else begin
         if (stream_end) begin
            r_pend <= 1'b1;
         end
         if (w_end_seen && w_all_idle) begin
            rx_finish <= 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sti_rx_unpack.sv
`default_nettype none
// ============================================================================
// Module      : tb_sti_rx_unpack
// Description : Directed self-checking bench for sti_rx_unpack.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sti_rx_unpack;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        si_data = 1'b0;
   logic        si_valid = 1'b0;
   logic        stream_end = 1'b0;
   logic [31:0] rx_word;
   logic [5:0]  rx_len;
   logic        rx_word_valid;
   logic        rx_err;
   logic        mem_wr;
   logic [7:0]  mem_addr;
   logic [7:0]  mem_data;
   logic        rx_finish;

   sti_rx_unpack #(.ADDR_W(8)) dut (
      .clk           (clk),
      .reset         (reset),
      .si_data       (si_data),
      .si_valid      (si_valid),
      .stream_end    (stream_end),
      .rx_word       (rx_word),
      .rx_len        (rx_len),
      .rx_word_valid (rx_word_valid),
      .rx_err        (rx_err),
      .mem_wr        (mem_wr),
      .mem_addr      (mem_addr),
      .mem_data      (mem_data),
      .rx_finish     (rx_finish)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Event log gathered on the falling edge, away from the active edge.
   int          cyc = 0;
   logic [7:0]  wa_q[$];
   logic [7:0]  wd_q[$];
   int          wc_q[$];
   int          nv = 0;
   int          ne = 0;
   int          vcyc = 0;
   logic [31:0] lw = '0;
   logic [5:0]  ll = '0;
   int          fin_cyc = -1;

   // Record writes, word pulses, error pulses and the first finish cycle.
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (mem_wr) begin
         wa_q.push_back(mem_addr);
         wd_q.push_back(mem_data);
         wc_q.push_back(cyc);
      end
      if (rx_word_valid) begin
         nv   = nv + 1;
         lw   = rx_word;
         ll   = rx_len;
         vcyc = cyc;
      end
      if (rx_err) ne = ne + 1;
      if (rx_finish && fin_cyc < 0) fin_cyc = cyc;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b0; si_valid = 1'b0; si_data = 1'b0; stream_end = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
   endtask

   // Send len bits of d MSB first, pulse stream_end with bit number end_at
   // (counted from 0; -1 for none), then a gap and drain time.
   task automatic send_frame(input logic [63:0] d, input int len, input int end_at);
      for (int i = len - 1; i >= 0; i--) begin
         @(posedge clk); #1;
         si_valid   = 1'b1;
         si_data    = d[i];
         stream_end = ((len - 1 - i) == end_at);
      end
      @(posedge clk); #1;
      si_valid = 1'b0; si_data = 1'b0; stream_end = 1'b0;
      repeat (8) @(posedge clk);
      #1;
   endtask

   int b_nv, b_ne, b_w;

   task automatic snap();
      b_nv = nv; b_ne = ne; b_w = wa_q.size();
   endtask

   initial begin
      // ---------------- reset state ----------------
      do_reset();
      @(negedge clk);
      check("reset_outputs",
            {rx_word, rx_len, rx_word_valid, rx_err, mem_wr, mem_addr, mem_data, rx_finish},
            64'd0);

      // ---------------- 8-bit frame 0xA5 ----------------
      snap();
      send_frame(64'hA5, 8, -1);
      check("a5_nvalid", nv - b_nv, 1);
      check("a5_word",   lw, 32'h0000_00A5);
      check("a5_len",    ll, 6'd8);
      check("a5_nwr",    wa_q.size() - b_w, 1);
      check("a5_addr",   wa_q[b_w], 8'h00);
      check("a5_data",   wd_q[b_w], 8'hA5);
      check("a5_lat",    wc_q[b_w] - vcyc, 1);

      // ---------------- 32-bit then 16-bit ----------------
      do_reset();
      snap();
      send_frame(64'h1234_5678, 32, -1);
      check("w32_word", lw, 32'h1234_5678);
      check("w32_len",  ll, 6'd32);
      check("w32_nwr",  wa_q.size() - b_w, 4);
      check("w32_b0", {wa_q[b_w+0], wd_q[b_w+0], 8'(wc_q[b_w+0] - vcyc)}, {8'd0, 8'h12, 8'd1});
      check("w32_b1", {wa_q[b_w+1], wd_q[b_w+1], 8'(wc_q[b_w+1] - vcyc)}, {8'd1, 8'h34, 8'd2});
      check("w32_b2", {wa_q[b_w+2], wd_q[b_w+2], 8'(wc_q[b_w+2] - vcyc)}, {8'd2, 8'h56, 8'd3});
      check("w32_b3", {wa_q[b_w+3], wd_q[b_w+3], 8'(wc_q[b_w+3] - vcyc)}, {8'd3, 8'h78, 8'd4});
      snap();
      send_frame(64'hBEEF, 16, -1);
      check("w16_word", {lw, ll}, {32'h0000_BEEF, 6'd16});
      check("w16_nwr",  wa_q.size() - b_w, 2);
      check("w16_b0",   {wa_q[b_w+0], wd_q[b_w+0]}, {8'd4, 8'hBE});
      check("w16_b1",   {wa_q[b_w+1], wd_q[b_w+1]}, {8'd5, 8'hEF});

      // ---------------- bad length and overflow ----------------
      snap();
      send_frame(64'hABC, 12, -1);
      check("b12_err",    ne - b_ne, 1);
      check("b12_nvalid", nv - b_nv, 0);
      check("b12_nwr",    wa_q.size() - b_w, 0);
      snap();
      send_frame(64'h12_3456_789A, 40, -1);
      check("b40_err",    ne - b_ne, 1);
      check("b40_nvalid", nv - b_nv, 0);
      check("b40_nwr",    wa_q.size() - b_w, 0);
      snap();
      send_frame(64'h3C, 8, -1);
      check("after_err_word", {lw, ll}, {32'h0000_003C, 6'd8});
      check("after_err_wr",   {wa_q[b_w], wd_q[b_w]}, {8'd6, 8'h3C});

      // ---------------- address wrap ----------------
      // Pointer is 7; 62 four-byte frames advance it to 255.
      for (int f = 0; f < 62; f++) send_frame(64'h0102_0304, 32, -1);
      snap();
      send_frame(64'hCAFE, 16, -1);
      check("wrap_nwr", wa_q.size() - b_w, 2);
      check("wrap_b0",  {wa_q[b_w+0], wd_q[b_w+0]}, {8'd255, 8'hCA});
      check("wrap_b1",  {wa_q[b_w+1], wd_q[b_w+1]}, {8'd0,   8'hFE});

      // ---------------- stream_end mid-frame ----------------
      do_reset();
      snap();
      send_frame(64'hC0FFEE, 24, 12);
      check("end_nwr", wa_q.size() - b_w, 3);
      check("end_b0",  {wa_q[b_w+0], wd_q[b_w+0]}, {8'd0, 8'hC0});
      check("end_b1",  {wa_q[b_w+1], wd_q[b_w+1]}, {8'd1, 8'hFF});
      check("end_b2",  {wa_q[b_w+2], wd_q[b_w+2]}, {8'd2, 8'hEE});
      check("end_finish", rx_finish, 1'b1);
      check("end_after_writes", (fin_cyc > wc_q[b_w+2]) ? 1 : 0, 1);
      snap();
      send_frame(64'h77, 8, -1);
      check("post_finish_quiet", {8'(nv - b_nv), 8'(ne - b_ne), 8'(wa_q.size() - b_w)}, 24'd0);
      check("finish_sticky", rx_finish, 1'b1);

      // ---------------- reset mid-frame ----------------
      do_reset();
      for (int i = 15; i >= 6; i--) begin
         @(posedge clk); #1;
         si_valid = 1'b1;
         si_data  = 1'(16'h1234 >> i);
         if (i == 6) reset = 1'b0;      // asserted during bit 10
      end
      @(posedge clk);
      @(negedge clk);
      check("midreset_outputs",
            {rx_word, rx_len, rx_word_valid, rx_err, mem_wr, mem_addr, mem_data, rx_finish},
            64'd0);
      si_valid = 1'b0; si_data = 1'b0; reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      snap();
      send_frame(64'h5A, 8, -1);
      check("midreset_nwr", wa_q.size() - b_w, 1);
      check("midreset_wr",  {wa_q[b_w], wd_q[b_w]}, {8'd0, 8'h5A});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/sti_rx_unpack.md
# sti_rx_unpack

Serial receiver and byte unpacker that sits directly downstream of the serial transmitter stage. It samples the transmitter's serial bit stream (data plus valid), rebuilds each frame into a right-aligned word, and reports frame length. It then unpacks each good word into 8-bit pixel writes on sequential memory addresses. It also flags malformed frames and raises a sticky finish flag once the upstream stream has ended and all writes have drained.

## Interface
Parameters:
- ADDR_W, 8, pixel memory address width; addresses wrap modulo 2^ADDR_W.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-low (asserted when 0).
- si_data  in  1  serial data bit, MSB of the frame first.
- si_valid  in  1  high for every bit of a frame; contiguous per frame; low ≥1 cycle between frames.
- stream_end  in  1  single-cycle pulse: upstream has sent its last frame.
- rx_word  out  32  last received frame, right-aligned, upper bits zero.
- rx_len  out  6  bit length of rx_word (8/16/24/32).
- rx_word_valid  out  1  one-cycle pulse: rx_word/rx_len updated.
- rx_err  out  1  one-cycle pulse: frame discarded (bad length or overflow).
- mem_wr  out  1  pixel write strobe.
- mem_addr  out  ADDR_W  write address.
- mem_data  out  8  write data.
- rx_finish  out  1  sticky done flag.

## Operation
- Reset values: all outputs 0, both FSMs idle, shift register/counters 0, write address pointer 0, pending-end flag 0.
- Receiver FSM, states R_IDLE, R_SHIFT, R_DROP:
  - R_IDLE: si_valid=1 → shreg={31'b0,si_data}, cnt=1, go R_SHIFT.
  - R_SHIFT, si_valid=1, cnt<32 → shreg={shreg[30:0],si_data}, cnt+1.
  - R_SHIFT, si_valid=1, cnt=32 (33rd bit) → rx_err pulse, go R_DROP.
  - R_SHIFT, si_valid=0 → frame end. If cnt∈{8,16,24,32}: rx_word=shreg, rx_len=cnt, rx_word_valid pulse, load packer (word, byte count cnt/8). Otherwise rx_err pulse with no output update. Either case → R_IDLE.
  - R_DROP: ignore bits until si_valid=0, then R_IDLE. No extra rx_err.
- Packer FSM, states P_IDLE, P_WRITE:
  - Load from receiver → P_WRITE with bytes remaining = n.
  - P_WRITE: one byte per cycle, most significant byte of the frame first. For byte k (k=n-1 down to 0), mem_data=word[8k+7:8k], mem_wr=1, mem_addr=pointer. Pointer +1 after each write, wrapping (2^ADDR_W−1)→0. After last byte → P_IDLE, mem_wr=0.
  - The packer runs concurrently with reception of the next frame. Max 4 writes is shorter than the 9-cycle minimum frame-plus-gap, so no overlap is possible.
- Finish:
  - stream_end sets pending-end.
  - rx_finish rises on the first cycle with pending-end=1, receiver R_IDLE, packer P_IDLE, and no load in flight. It stays 1 until reset.
  - After rx_finish, si_valid is ignored and no further rx_word_valid, rx_err or mem_wr occur.
- stream_end during a frame or while writes drain: finish waits for the frame and its writes to complete. The final frame is not lost.
- Reset low mid-frame or mid-write: the next edge returns everything to reset values. The partial frame is dropped and the address pointer returns to 0.

## Timing
- Edge E samples the first si_valid=0 after the last bit. At E, rx_word_valid (or rx_err) is registered, so the pulse is visible in the cycle after E.
- First mem_wr is one cycle after rx_word_valid. Remaining bytes follow on consecutive cycles: n cycles of mem_wr per frame.
- mem_addr/mem_data are valid in the same cycle as mem_wr. mem_data holds its last value when mem_wr=0.
- Frame latency, last bit to last write: 1 + n cycles.
- rx_finish rises ≥1 cycle after the last mem_wr deasserts, or 1 cycle after stream_end if everything is idle.

## Test plan
- 8-bit frame 0xA5 → rx_word=0x000000A5, rx_len=8, one pulse; one write addr 0 data 0xA5.
- 32-bit frame 0x12345678 → rx_len=32; writes 0x12,0x34,0x56,0x78 at addr 0..3 on consecutive cycles; then a 16-bit 0xBEEF → addrs 4,5.
- 12-bit frame → rx_err single pulse, no rx_word_valid, no mem_wr, pointer unchanged. 40-bit burst → one rx_err at bit 33, nothing written, next 8-bit frame is received normally.
- Pointer at 255 with a 16-bit frame 0xCAFE → 0xCA at addr 255, 0xFE at addr 0.
- stream_end pulsed mid-way through a 24-bit frame → all 3 writes occur, then rx_finish=1 and stays high. A later frame produces no outputs.
- reset=0 during bit 10 of a 16-bit frame → all outputs 0 next cycle. A fresh 8-bit frame after release writes addr 0.
